mem_sched: RTL and testbench
============================

# mem_sched

Request scheduler sharing one external SRAM port among three requesters: instruction fetch (IF), execute-stage load/store (EXE) and the VGA line-fetch engine (VGA). It sits between the pipeline/VGA logic and the SRAM sequencer. It serialises accesses, applies fixed priority with an IF anti-starvation boost, and returns a one-cycle acknowledge carrying read data to the winning requester.

## Interface
Parameters:
- ADDR_W, 18, SRAM word-address width
- DATA_W, 16, data width
- STARVE_LIM, 4, consecutive grants to others while IF waits before IF is boosted (1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  IF request, held until if_ack
- if_addr  in  ADDR_W  IF read address
- if_ack  out  1  one-cycle IF completion pulse
- if_rdata  out  DATA_W  IF read data, valid while if_ack=1
- exe_req  in  1  EXE request, held until exe_ack
- exe_we  in  1  1=write, 0=read
- exe_addr  in  ADDR_W  EXE address
- exe_wdata  in  DATA_W  EXE write data
- exe_ack  out  1  one-cycle EXE completion pulse
- exe_rdata  out  DATA_W  EXE read data, valid while exe_ack=1 and access was a read
- vga_req  in  1  VGA request, held until vga_ack
- vga_addr  in  ADDR_W  VGA read address
- vga_ack  out  1  one-cycle VGA completion pulse
- vga_rdata  out  DATA_W  VGA read data, valid while vga_ack=1
- mem_req  out  1  access request to the SRAM sequencer, held until mem_done
- mem_we  out  1  write enable for current access
- mem_addr  out  ADDR_W  current access address
- mem_wdata  out  DATA_W  current write data
- mem_done  in  1  one-cycle completion pulse from the sequencer
- mem_rdata  in  DATA_W  read data, valid with mem_done
- grant_id  out  2  current owner: 0 none, 1 IF, 2 EXE, 3 VGA (debug)

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req is high, latch the winner's addr/we/wdata into registers, set grant_id, and go to BUSY. Otherwise stay.
- Priority: EXE > VGA > IF. Exception: when starve_cnt == STARVE_LIM and if_req=1, IF wins.
- BUSY: mem_req=1; mem_we/addr/wdata are driven from the latched registers and stay stable. On mem_done, capture mem_rdata and go to RESP.
- RESP: pulse the owner's ack for exactly one cycle with its rdata, clear grant_id, go to IDLE. mem_req is 0 in RESP.
- IF and VGA are always reads (mem_we=0). mem_wdata is don't-care for reads and is driven with the latched value.
- starve_cnt is 4 bits:
  - +1 on each grant to EXE or VGA while if_req=1.
  - Saturates at STARVE_LIM.
  - Cleared on an IF grant or whenever if_req=0 in IDLE.
- Requester drops req while owning the port (protocol violation): the access still completes on the bus. RESP is still visited, but no ack is pulsed and the rdata is discarded.
- mem_done outside BUSY is ignored.
- rdata outputs hold their last value between acks.

## Timing
- Reset values:
  - State IDLE.
  - mem_req, mem_we, if_ack, exe_ack, vga_ack all 0.
  - mem_addr, mem_wdata, all rdata 0.
  - grant_id 0, starve_cnt 0.
- Reset mid-access: mem_req drops the cycle after rst is sampled. The outstanding access is abandoned and no ack is issued.
- Request sampled at edge N in IDLE → mem_req=1 from N+1.
- mem_done sampled at edge M → ack=1 during cycle M+1 (RESP).
- Next grant is sampled at M+2 at the earliest.
- Minimum total latency req→ack with a 1-cycle sequencer is 3 cycles. Minimum back-to-back issue spacing is 3 cycles plus sequencer time.
- Requests arriving during BUSY/RESP wait; the winner is re-evaluated in IDLE.
- Requester may deassert req the cycle after its ack. If req stays high after ack, it is treated as a new request.

## Structure
- Shared package/defines file: ADDR_W and DATA_W (existing `MemAddr`/`MemValue` widths), grant_id encodings GNT_NONE/IF/EXE/VGA, and state encodings.
- One sub-module: mem_sched_prio, the combinational priority picker. It takes the three reqs and the starve flag and returns a one-hot grant. The rest stays in mem_sched.

## Test plan
- Single IF read of 0x00100; sequencer returns 0x1234 after 2 cycles → if_ack pulses once with if_rdata=0x1234, latency 4 cycles, mem_we=0 throughout.
- EXE write 0x00200 ← 0xBEEF while IF and VGA are also requesting → EXE granted first with mem_we=1, mem_wdata=0xBEEF; VGA second, IF third.
- EXE and VGA requesting continuously, IF held high, STARVE_LIM=4 → IF is granted after exactly 4 foreign grants; starve_cnt resets to 0.
- EXE drops exe_req during BUSY → bus access completes, no exe_ack, and the next grant proceeds normally.
- rst asserted during BUSY → next cycle mem_req=0, all acks 0, grant_id=0; a subsequent IF request is served normally.
- Spurious mem_done pulse in IDLE → no state change and no ack.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared widths, grant-owner codes and scheduler state encoding for the
// SRAM request scheduler and its priority picker.
package mem_sched_pkg;

    localparam int MEM_ADDR_W = 18;
    localparam int MEM_DATA_W = 16;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_EXE  = 2'd2;
    localparam logic [1:0] GNT_VGA  = 2'd3;

    // Bit positions inside the one-hot grant vector from the picker.
    localparam int GB_IF  = 0;
    localparam int GB_EXE = 1;
    localparam int GB_VGA = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

    function automatic logic [1:0] grant_code(input logic [2:0] onehot);
        logic [1:0] code;
        code = GNT_NONE;
        if (onehot[GB_EXE])
            code = GNT_EXE;
        else if (onehot[GB_VGA])
            code = GNT_VGA;
        else if (onehot[GB_IF])
            code = GNT_IF;
        return code;
    endfunction

endpackage

// File: rtl/mem_sched_prio.sv
// Combinational fixed-priority picker: EXE > VGA > IF, except that a
// starved IF jumps the queue. Output is one-hot (or zero when nobody asks).
module mem_sched_prio
    import mem_sched_pkg::*;
(
    input  logic       if_req,
    input  logic       exe_req,
    input  logic       vga_req,
    input  logic       starve,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        if (starve && if_req)
            grant[GB_IF] = 1'b1;
        else if (exe_req)
            grant[GB_EXE] = 1'b1;
        else if (vga_req)
            grant[GB_VGA] = 1'b1;
        else if (if_req)
            grant[GB_IF] = 1'b1;
    end

endmodule

// File: rtl/mem_sched.sv
// Serialises IF / EXE / VGA accesses onto a single SRAM sequencer port and
// returns a one-cycle ack with read data to the requester that owned the port.
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              exe_req,
    input  logic              exe_we,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic              exe_ack,
    output logic [DATA_W-1:0] exe_rdata,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        grant_id,
    output logic [1:0]        dbg_state
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    sched_state_t state;
    logic [3:0]   starve_cnt;
    logic         owner_dropped;
    logic         owner_req;
    logic         starve;
    logic [2:0]   pick;

    assign starve    = (starve_cnt == LIM);
    assign dbg_state = state;

    mem_sched_prio u_prio (
        .if_req  (if_req),
        .exe_req (exe_req),
        .vga_req (vga_req),
        .starve  (starve),
        .grant   (pick)
    );

    // Live request line of whoever currently owns the port.
    always_comb begin
        owner_req = 1'b0;
        case (grant_id)
            GNT_IF:  owner_req = if_req;
            GNT_EXE: owner_req = exe_req;
            GNT_VGA: owner_req = vga_req;
            default: owner_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            grant_id      <= GNT_NONE;
            starve_cnt    <= 4'd0;
            owner_dropped <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if_ack        <= 1'b0;
            exe_ack       <= 1'b0;
            vga_ack       <= 1'b0;
            if_rdata      <= '0;
            exe_rdata     <= '0;
            vga_rdata     <= '0;
        end else begin
            if_ack  <= 1'b0;
            exe_ack <= 1'b0;
            vga_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!if_req)
                        starve_cnt <= 4'd0;
                    if (pick != 3'b000) begin
                        state         <= ST_BUSY;
                        mem_req       <= 1'b1;
                        owner_dropped <= 1'b0;
                        grant_id      <= grant_code(pick);
                        if (pick[GB_EXE]) begin
                            mem_addr  <= exe_addr;
                            mem_we    <= exe_we;
                            mem_wdata <= exe_wdata;
                        end else if (pick[GB_VGA]) begin
                            mem_addr <= vga_addr;
                            mem_we   <= 1'b0;
                        end else begin
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                        end
                        // IF waiting behind a foreign grant ages toward the boost.
                        if (pick[GB_IF])
                            starve_cnt <= 4'd0;
                        else if (if_req && starve_cnt != LIM)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end

                ST_BUSY: begin
                    if (mem_done) begin
                        state   <= ST_RESP;
                        mem_req <= 1'b0;
                        // Ack is registered here so it is visible during RESP.
                        if (owner_req && !owner_dropped) begin
                            case (grant_id)
                                GNT_IF: begin
                                    if_ack   <= 1'b1;
                                    if_rdata <= mem_rdata;
                                end
                                GNT_EXE: begin
                                    exe_ack <= 1'b1;
                                    if (!mem_we)
                                        exe_rdata <= mem_rdata;
                                end
                                GNT_VGA: begin
                                    vga_ack   <= 1'b1;
                                    vga_rdata <= mem_rdata;
                                end
                                default: ;
                            endcase
                        end
                    end else if (!owner_req) begin
                        owner_dropped <= 1'b1;
                    end
                end

                ST_RESP: begin
                    state    <= ST_IDLE;
                    grant_id <= GNT_NONE;
                end

                default: begin
                    state    <= ST_IDLE;
                    grant_id <= GNT_NONE;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sched.sv
// Directed + random bench for mem_sched with a transaction-level model of
// arbitration, starvation aging, sequencer timing and memory contents.
module tb_mem_sched;
    import mem_sched_pkg::*;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int LIM = 4;
    localparam logic [1:0] G_NONE = 2'd0, G_IF = 2'd1, G_EXE = 2'd2, G_VGA = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, exe_req, vga_req, exe_we, mem_done;
    logic [AW-1:0] if_addr, exe_addr, vga_addr;
    logic [DW-1:0] exe_wdata, mem_rdata;
    logic          if_ack, exe_ack, vga_ack, mem_req, mem_we;
    logic [DW-1:0] if_rdata, exe_rdata, vga_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant_id, dbg_state;

    always #5 clk = ~clk;

    mem_sched #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .exe_req(exe_req), .exe_we(exe_we), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
        .exe_ack(exe_ack), .exe_rdata(exe_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requesters, indexed by their grant code.
    logic          rq_req[4];
    logic [AW-1:0] rq_addr[4];
    logic          rq_we[4];
    logic [DW-1:0] rq_wdata[4];
    logic          rq_auto[4];
    int            obs_ack[4];

    // Reference model.
    logic [DW-1:0] mem_model[int];
    logic [DW-1:0] last_rdata[4];
    logic [1:0]    grant_log[$];
    bit            inflight, own_dropped, done_sent, own_we;
    logic [1:0]    own;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    int            avail_edge, seq_wait, starve, last_ack_edge;
    int            seq_k_fixed = -1;
    bit            force_spurious = 0;
    bit            rst_drive = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        if (mem_model.exists(int'(a)))
            return mem_model[int'(a)];
        return {a[7:0], ~a[7:0]};
    endfunction

    function automatic logic [1:0] winner(input logic i, input logic e, input logic v, input int sc);
        if (i && sc == LIM) return G_IF;
        if (e) return G_EXE;
        if (v) return G_VGA;
        if (i) return G_IF;
        return G_NONE;
    endfunction

    task automatic new_request(input int r);
        rq_req[r]   = 1'b1;
        rq_addr[r]  = AW'($urandom_range(0, 15));
        rq_we[r]    = (r == int'(G_EXE)) ? 1'($urandom_range(0, 1)) : 1'b0;
        rq_wdata[r] = DW'($urandom);
    endtask

    task automatic chk_acks(input string tag, input logic [1:0] who);
        chk({tag, "_if_ack"},  32'(if_ack),  32'(who == G_IF));
        chk({tag, "_exe_ack"}, 32'(exe_ack), 32'(who == G_EXE));
        chk({tag, "_vga_ack"}, 32'(vga_ack), 32'(who == G_VGA));
    endtask

    // One clock: drive at negedge, then check the state after the rising edge.
    task automatic tick();
        logic d_rst, d_done, d_if, d_exe, d_vga, d_own_req, give;
        logic [1:0] w;
        @(negedge clk);
        d_rst = rst_drive;
        rst = d_rst;
        if_req = rq_req[G_IF];   if_addr = rq_addr[G_IF];
        exe_req = rq_req[G_EXE]; exe_addr = rq_addr[G_EXE];
        exe_we = rq_we[G_EXE];   exe_wdata = rq_wdata[G_EXE];
        vga_req = rq_req[G_VGA]; vga_addr = rq_addr[G_VGA];
        d_if = if_req; d_exe = exe_req; d_vga = vga_req;
        d_done = 1'b0;
        mem_rdata = DW'($urandom);
        if (inflight && !done_sent) begin
            if (seq_wait <= 1) begin
                d_done = 1'b1;
                done_sent = 1'b1;
                mem_rdata = rd_val(mem_addr);
            end else begin
                seq_wait--;
            end
        end else if (force_spurious) begin
            d_done = 1'b1;
        end
        force_spurious = 0;
        mem_done = d_done;
        d_own_req = rq_req[own];

        @(posedge clk);
        #1;
        cyc++;
        if (if_ack)  obs_ack[G_IF]++;
        if (exe_ack) obs_ack[G_EXE]++;
        if (vga_ack) obs_ack[G_VGA]++;

        if (d_rst) begin
            inflight = 0; done_sent = 0; starve = 0;
            avail_edge = cyc + 1;
            for (int r = 0; r < 4; r++) last_rdata[r] = '0;
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_grant_id", 32'(grant_id), 32'(G_NONE));
            chk_acks("rst", G_NONE);
        end else if (inflight && d_done) begin
            give = d_own_req && !own_dropped;
            chk("done_mem_req", 32'(mem_req), 32'd0);
            chk_acks("done", give ? own : G_NONE);
            if (own == G_EXE && own_we)
                mem_model[int'(own_addr)] = own_wdata;
            else if (give)
                last_rdata[own] = rd_val(own_addr);
            inflight = 0;
            avail_edge = cyc + 2;
            if (give) begin
                last_ack_edge = cyc;
                if (rq_auto[own]) new_request(int'(own));
                else rq_req[own] = 1'b0;
            end
        end else if (inflight) begin
            if (!d_own_req) own_dropped = 1;
            chk("busy_mem_req", 32'(mem_req), 32'd1);
            chk("busy_mem_addr", 32'(mem_addr), 32'(own_addr));
            chk("busy_mem_we", 32'(mem_we), 32'(own_we));
            if (own_we) chk("busy_mem_wdata", 32'(mem_wdata), 32'(own_wdata));
            chk("busy_grant_id", 32'(grant_id), 32'(own));
            chk_acks("busy", G_NONE);
        end else if (cyc >= avail_edge) begin
            w = winner(d_if, d_exe, d_vga, starve);
            if (!d_if || w == G_IF) starve = 0;
            else if (w != G_NONE && starve < LIM) starve++;
            chk("arb_grant_id", 32'(grant_id), 32'(w));
            chk("arb_mem_req", 32'(mem_req), 32'(w != G_NONE));
            chk_acks("arb", G_NONE);
            if (w != G_NONE) begin
                own = w;
                own_addr = rq_addr[w];
                own_we = (w == G_EXE) ? rq_we[G_EXE] : 1'b0;
                own_wdata = rq_wdata[w];
                own_dropped = 0;
                done_sent = 0;
                inflight = 1;
                seq_wait = ((seq_k_fixed >= 0) ? seq_k_fixed : int'($urandom_range(0, 3))) + 1;
                grant_log.push_back(w);
                chk("arb_mem_addr", 32'(mem_addr), 32'(own_addr));
                chk("arb_mem_we", 32'(mem_we), 32'(own_we));
                if (own_we) chk("arb_mem_wdata", 32'(mem_wdata), 32'(own_wdata));
            end
        end else begin
            chk("resp_mem_req", 32'(mem_req), 32'd0);
            chk("resp_grant_id", 32'(grant_id), 32'(G_NONE));
            chk_acks("resp", G_NONE);
        end
        chk("if_rdata_hold", 32'(if_rdata), 32'(last_rdata[G_IF]));
        chk("exe_rdata_hold", 32'(exe_rdata), 32'(last_rdata[G_EXE]));
        chk("vga_rdata_hold", 32'(vga_rdata), 32'(last_rdata[G_VGA]));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((inflight || rq_req[G_IF] || rq_req[G_EXE] || rq_req[G_VGA] || cyc < avail_edge)
               && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_inflight(input string tag, input int budget);
        int n;
        n = 0;
        while (!inflight && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, req_edge, base;
        rst = 1'b1;
        if_req = 0; exe_req = 0; vga_req = 0; exe_we = 0; mem_done = 0;
        if_addr = '0; exe_addr = '0; vga_addr = '0; exe_wdata = '0; mem_rdata = '0;
        for (int r = 0; r < 4; r++) begin
            rq_req[r] = 0; rq_addr[r] = '0; rq_we[r] = 0; rq_wdata[r] = '0;
            rq_auto[r] = 0; obs_ack[r] = 0; last_rdata[r] = '0;
        end
        inflight = 0; own = G_NONE; starve = 0; avail_edge = 0; last_ack_edge = -1;

        // Reset values.
        rst_drive = 1;
        tick(); tick();
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_drive = 0;
        tick(); tick();

        // Single IF read, sequencer answers two cycles after mem_req appears.
        mem_model[int'(18'h00100)] = 16'h1234;
        seq_k_fixed = 2;
        rq_req[G_IF] = 1; rq_addr[G_IF] = 18'h00100;
        req_edge = cyc + 1;
        base = obs_ack[G_IF];
        wait_idle("if_read", 20);
        chk("if_read_ack_count", 32'(obs_ack[G_IF] - base), 32'd1);
        chk("if_read_latency", 32'(last_ack_edge + 1 - req_edge), 32'd4);
        chk("if_read_data", 32'(if_rdata), 32'h1234);

        // EXE write competing with VGA and IF: EXE, then VGA, then IF.
        seq_k_fixed = 0;
        grant_log.delete();
        rq_req[G_EXE] = 1; rq_we[G_EXE] = 1; rq_addr[G_EXE] = 18'h00200; rq_wdata[G_EXE] = 16'hBEEF;
        rq_req[G_VGA] = 1; rq_addr[G_VGA] = 18'h00300;
        rq_req[G_IF]  = 1; rq_addr[G_IF]  = 18'h00101;
        wait_idle("three_way", 60);
        chk("order_0", 32'(grant_log.size() > 0 ? grant_log[0] : G_NONE), 32'(G_EXE));
        chk("order_1", 32'(grant_log.size() > 1 ? grant_log[1] : G_NONE), 32'(G_VGA));
        chk("order_2", 32'(grant_log.size() > 2 ? grant_log[2] : G_NONE), 32'(G_IF));
        rq_req[G_IF] = 1; rq_addr[G_IF] = 18'h00200;
        wait_idle("readback", 20);
        chk("readback_data", 32'(if_rdata), 32'hBEEF);

        // Continuous EXE/VGA traffic with IF waiting: IF every fifth grant.
        grant_log.delete();
        for (int r = 1; r < 4; r++) begin
            rq_auto[r] = 1;
            new_request(r);
        end
        n = 0;
        while (grant_log.size() < 10 && n < 300) begin
            tick();
            n++;
        end
        for (int r = 1; r < 4; r++) rq_auto[r] = 0;
        chk("starve_timeout", 32'(n >= 300), 32'd0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("starve_grant_%0d", i),
                32'(i < grant_log.size() ? grant_log[i] : G_NONE),
                32'((i % 5 == 4) ? G_IF : G_EXE));
        wait_idle("starve_drain", 100);

        // EXE abandons its request while owning the port.
        seq_k_fixed = 3;
        base = obs_ack[G_EXE];
        rq_req[G_EXE] = 1; rq_we[G_EXE] = 0; rq_addr[G_EXE] = 18'h00042;
        wait_inflight("drop_grant", 10);
        rq_req[G_EXE] = 0;
        wait_idle("drop", 20);
        chk("drop_no_ack", 32'(obs_ack[G_EXE] - base), 32'd0);
        base = obs_ack[G_VGA];
        rq_req[G_VGA] = 1; rq_addr[G_VGA] = 18'h00007;
        wait_idle("after_drop", 20);
        chk("after_drop_vga_ack", 32'(obs_ack[G_VGA] - base), 32'd1);

        // Reset while an access is outstanding.
        rq_req[G_IF] = 1; rq_addr[G_IF] = 18'h00005;
        wait_inflight("rst_busy_grant", 10);
        tick();
        for (int r = 0; r < 4; r++) rq_req[r] = 0;
        rst_drive = 1;
        tick();
        rst_drive = 0;
        chk("rst_busy_state", 32'(dbg_state), 32'(ST_IDLE));
        tick(); tick();
        seq_k_fixed = 1;
        base = obs_ack[G_IF];
        rq_req[G_IF] = 1; rq_addr[G_IF] = 18'h00100;
        wait_idle("post_rst", 20);
        chk("post_rst_ack", 32'(obs_ack[G_IF] - base), 32'd1);
        chk("post_rst_data", 32'(if_rdata), 32'h1234);

        // Stray mem_done while idle.
        force_spurious = 1;
        tick();
        chk("spurious_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        chk("spurious_state2", 32'(dbg_state), 32'(ST_IDLE));

        // Random traffic, random sequencer latency, occasional drops and stray dones.
        seq_k_fixed = -1;
        for (int i = 0; i < 2000; i++) begin
            for (int r = 1; r < 4; r++)
                if (!rq_req[r] && $urandom_range(0, 3) == 0) new_request(r);
            if (inflight && rq_req[own] && $urandom_range(0, 99) == 0) rq_req[own] = 0;
            if (!inflight && $urandom_range(0, 49) == 0) force_spurious = 1;
            tick();
        end
        wait_idle("final_drain", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
